// File: rtl/dcsk_tx_ctrl.sv
// dcsk_tx_ctrl: DCSK chip modulator (reference half-bit then data-keyed copy); define DCSK_TX_FRAME_CNT_EN to add Frame_Cnt
module dcsk_tx_ctrl (
  input  logic        Clk,
  input  logic        N_Rst,
  input  logic        Tx_En,
  input  logic [4:0]  Spread_Factor,
  input  logic [31:0] Data_In,
  input  logic        Data_Load,
  input  logic        Chaos_Chip,
  output logic        Data_Ready,
  output logic        Chaos_Req,
  output logic        Tx_Chip,
  output logic        Tx_Valid,
  output logic        Busy,
  output logic        Frame_Done
`ifdef DCSK_TX_FRAME_CNT_EN
  ,
  output logic [7:0]  Frame_Cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REF_PHASE, INFO_PHASE} state_t;
  state_t      state;
  logic [31:0] hold, active;
  logic        hold_full;
  logic [15:0] delay;
  logic [3:0]  addr, sf_m1, sf_in_m1;
  logic [4:0]  bit_idx;
  logic        half_end, frame_end;
  // Clamp requested SF to 2..16, held as SF-1 so it compares directly with the 4-bit chip address
  always_comb begin
    sf_in_m1 = Spread_Factor < 5'd2 ? 4'd1 : Spread_Factor > 5'd16 ? 4'd15 : 4'(Spread_Factor - 5'd1);
    half_end = addr == sf_m1;
    frame_end = state == INFO_PHASE && Tx_En && half_end && bit_idx == 5'd31;
  end
  assign Data_Ready = !hold_full;
  assign Chaos_Req = state == REF_PHASE;
  assign Busy = state != IDLE;
  // Sequencer: hold/active word handling, reference capture and info chip generation
  always_ff @(posedge Clk or negedge N_Rst)
    if (!N_Rst) begin
      state <= IDLE;
      hold <= '0;
      hold_full <= 1'b0;
      active <= '0;
      delay <= '0;
      addr <= '0;
      sf_m1 <= 4'd1;
      bit_idx <= '0;
      Tx_Chip <= 1'b0;
      Tx_Valid <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      if (Data_Load && !hold_full) begin
        hold <= Data_In;
        hold_full <= 1'b1;
      end
      Tx_Chip <= 1'b0;
      Tx_Valid <= 1'b0;
      Frame_Done <= 1'b0;
      if (state != IDLE && !Tx_En) begin
        state <= IDLE;
        active <= '0;
        addr <= '0;
        bit_idx <= '0;
      end else
        case (state)
          IDLE:
            if (Tx_En && hold_full) begin
              state <= REF_PHASE;
              active <= hold;
              hold_full <= 1'b0;
              addr <= '0;
              bit_idx <= '0;
              sf_m1 <= sf_in_m1;
            end
          REF_PHASE: begin
            delay[addr] <= Chaos_Chip;
            Tx_Chip <= Chaos_Chip;
            Tx_Valid <= 1'b1;
            addr <= half_end ? 4'd0 : addr + 4'd1;
            if (half_end) state <= INFO_PHASE;
          end
          INFO_PHASE: begin
            Tx_Chip <= ~(delay[addr] ^ active[bit_idx]);
            Tx_Valid <= 1'b1;
            addr <= half_end ? 4'd0 : addr + 4'd1;
            if (half_end && bit_idx != 5'd31) begin
              bit_idx <= bit_idx + 5'd1;
              state <= REF_PHASE;
              sf_m1 <= sf_in_m1;
            end else if (half_end) begin
              Frame_Done <= 1'b1;
              bit_idx <= '0;
              state <= hold_full ? REF_PHASE : IDLE;
              active <= hold_full ? hold : '0;
              hold_full <= 1'b0;
              sf_m1 <= sf_in_m1;
            end
          end
          default: state <= IDLE;
        endcase
    end
`ifdef DCSK_TX_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 8 bits
  always_ff @(posedge Clk or negedge N_Rst)
    if (!N_Rst) Frame_Cnt <= '0;
    else if (frame_end) Frame_Cnt <= Frame_Cnt + 8'd1;
`endif
endmodule

// File: tb/tb_dcsk_tx_ctrl.sv
// tb_dcsk_tx_ctrl: random/directed stimulus checked against a time-indexed DCSK frame model
module tb_dcsk_tx_ctrl;
  logic        Clk = 0, N_Rst = 0, Tx_En = 0, Data_Load = 0, Chaos_Chip = 0;
  logic [4:0]  Spread_Factor = 5'd4;
  logic [31:0] Data_In = '0;
  logic        Data_Ready, Chaos_Req, Tx_Chip, Tx_Valid, Busy, Frame_Done;
`ifdef DCSK_TX_FRAME_CNT_EN
  logic [7:0]  Frame_Cnt;
`endif
  int n_chk = 0, n_err = 0, e = 0;
  logic ch[65536], oc[65536], ov[65536], fd[65536], cr[65536], dr[65536], bz[65536];
  logic pat_on = 0;
  int pat_base = 0;
  logic [3:0]  p4 = 4'b1101;
  logic [15:0] pat16 = 16'b1011_1011_1011_0100;

  dcsk_tx_ctrl dut (
    .Clk(Clk), .N_Rst(N_Rst), .Tx_En(Tx_En), .Spread_Factor(Spread_Factor),
    .Data_In(Data_In), .Data_Load(Data_Load), .Chaos_Chip(Chaos_Chip),
    .Data_Ready(Data_Ready), .Chaos_Req(Chaos_Req), .Tx_Chip(Tx_Chip),
    .Tx_Valid(Tx_Valid), .Busy(Busy), .Frame_Done(Frame_Done)
`ifdef DCSK_TX_FRAME_CNT_EN
    , .Frame_Cnt(Frame_Cnt)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int eff(input logic [4:0] s);
    return s < 2 ? 2 : s > 16 ? 16 : int'(s);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: present chaos chip for edge e, then log what the DUT shows after edge e
  task automatic step();
    Chaos_Chip = pat_on ? p4[2'(e - pat_base)] : 1'($urandom);
    ch[e] = Chaos_Chip;
    @(posedge Clk);
    #1;
    oc[e] = Tx_Chip;
    ov[e] = Tx_Valid;
    fd[e] = Frame_Done;
    cr[e] = Chaos_Req;
    dr[e] = Data_Ready;
    bz[e] = Busy;
    e++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // load a word and enable; e0 is the edge at which the frame leaves Idle
  task automatic start(input logic [31:0] w, output int e0);
    Data_In = w;
    Data_Load = 1;
    step();
    Data_Load = 0;
    Tx_En = 1;
    e0 = e;
    step();
  endtask

  // chip c of the frame: bit c/(2SF); first SF chips are raw chaos, next SF are those chips XNOR the bit
  task automatic check_frame(input int e0, input logic [31:0] w, input int sf, input int n);
    for (int c = 0; c < n; c++) begin
      int b = c / (2 * sf);
      int i = c % (2 * sf);
      logic x = i < sf ? ch[e0 + 1 + c] : ~(ch[e0 + 1 + c - sf] ^ w[b]);
      chk($sformatf("chip%0d_sf%0d", c, sf),
          {3'b0, fd[e0 + 1 + c], ov[e0 + 1 + c], oc[e0 + 1 + c], cr[e0 + c], bz[e0 + c]},
          {3'b0, 1'(c == 64 * sf - 1), 1'b1, x, 1'(i < sf), 1'b1});
    end
  endtask

  initial begin
    int e0, e1, sf;
    logic [31:0] w, w2;
    N_Rst = 0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset", {2'b0, Tx_Chip, Tx_Valid, Frame_Done, Busy, Chaos_Req, Data_Ready}, 8'h01);
`ifdef DCSK_TX_FRAME_CNT_EN
    chk("reset_fcnt", Frame_Cnt, 8'h00);
`endif
    N_Rst = 1;
    step();
    Spread_Factor = 5'd4;
    start(32'h0000_0001, e0);
    pat_on = 1;
    pat_base = e0 + 1;
    run(258);
    pat_on = 0;
    check_frame(e0, 32'h0000_0001, 4, 256);
    for (int k = 0; k < 16; k++) chk("pattern_chip", {7'b0, oc[e0 + 1 + k]}, {7'b0, pat16[15 - k]});
    chk("last_chip_256", {6'b0, fd[e0 + 256], fd[e0 + 255]}, 8'h02);
    chk("idle_after", {5'b0, ov[e0 + 257], bz[e0 + 257], dr[e0 + 257]}, 8'h01);
    foreach (p4[k]) begin
      Spread_Factor = k == 0 ? 5'd0 : 5'd20;
      if (k > 1) break;
      sf = eff(Spread_Factor);
      w = $urandom;
      start(w, e0);
      run(64 * sf + 2);
      check_frame(e0, w, sf, 64 * sf);
      chk("clamp_end", {6'b0, ov[e0 + 64 * sf + 1], bz[e0 + 64 * sf]}, 8'h00);
    end
    Spread_Factor = 5'($urandom_range(2, 16));
    sf = eff(Spread_Factor);
    w = $urandom;
    w2 = $urandom;
    start(w, e0);
    run(9);
    Data_In = w2;
    Data_Load = 1;
    step();
    run(9);
    Data_In = ~w2;
    step();
    Data_Load = 0;
    run(128 * sf - 18);
    check_frame(e0, w, sf, 64 * sf);
    check_frame(e0 + 64 * sf, w2, sf, 64 * sf);
    chk("b2b_ready", {5'b0, dr[e0 + 9], dr[e0 + 10], dr[e0 + 64 * sf]}, 8'h05);
    Spread_Factor = 5'd4;
    w = $urandom;
    w2 = $urandom;
    Tx_En = 0;
    run(3);
    start(w, e0);
    run(4);
    Data_In = w2;
    Data_Load = 1;
    step();
    Data_Load = 0;
    run(41);
    Tx_En = 0;
    step();
    run(5);
    check_frame(e0, w, 4, 46);
    chk("abort", {3'b0, ov[e0 + 47], oc[e0 + 47], fd[e0 + 47], bz[e0 + 47], ov[e0 + 52]}, 8'h00);
    chk("abort_hold", {7'b0, dr[e0 + 52]}, 8'h00);
    Tx_En = 1;
    e1 = e;
    step();
    run(258);
    check_frame(e1, w2, 4, 256);
    Spread_Factor = 5'($urandom_range(2, 16));
    start($urandom, e0);
    run(10);
    Data_In = $urandom;
    Data_Load = 1;
    step();
    Data_Load = 0;
    run(10);
    chk("pre_reset_busy", {6'b0, Busy, Data_Ready}, 8'h02);
    N_Rst = 0;
    #2;
    chk("reset_mid", {2'b0, Tx_Chip, Tx_Valid, Frame_Done, Busy, Chaos_Req, Data_Ready}, 8'h01);
`ifdef DCSK_TX_FRAME_CNT_EN
    chk("reset_mid_fcnt", Frame_Cnt, 8'h00);
`endif
    @(posedge Clk);
    #1;
    N_Rst = 1;
    Tx_En = 0;
    run(3);
    chk("post_reset", {5'b0, ov[e - 1], fd[e - 1], dr[e - 1]}, 8'h01);
`ifdef DCSK_TX_FRAME_CNT_EN
    Spread_Factor = 5'd2;
    start($urandom, e0);
    for (int f = 0; f < 256; f++) begin
      for (int n = 0; n < 128; n++) begin
        Data_Load = f < 255 && n == 3;
        Data_In = $urandom;
        step();
      end
      Data_Load = 0;
      if (f == 0 || f == 254 || f == 255) chk("fcnt", Frame_Cnt, 8'(f + 1));
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
